// File: rtl/in_quant_packer_if.sv
// Bus bundle for in_quant_packer: raw feature stream in, packed code vector out,
// threshold configuration port and the framing-error flag.
interface in_quant_packer_if #(
   parameter int NUM_FEATURES = 16,
   parameter int IN_WIDTH     = 8
);
   localparam int BW     = 2;
   localparam int OUT_W  = NUM_FEATURES * BW;
   localparam int CFG_AW = $clog2(NUM_FEATURES) + 2;

   logic                s_valid;
   logic                s_ready;
   logic [IN_WIDTH-1:0] s_data;
   logic                s_last;
   logic                m_valid;
   logic                m_ready;
   logic [OUT_W-1:0]    m_data;
   logic                cfg_we;
   logic [CFG_AW-1:0]   cfg_addr;
   logic [IN_WIDTH-1:0] cfg_data;
   logic                err_frame;

   // slave = the packer itself, master = whatever feeds and drains it
   modport slave (
      input  s_valid, s_data, s_last, m_ready, cfg_we, cfg_addr, cfg_data,
      output s_ready, m_valid, m_data, err_frame
   );

   modport master (
      output s_valid, s_data, s_last, m_ready, cfg_we, cfg_addr, cfg_data,
      input  s_ready, m_valid, m_data, err_frame
   );
endinterface

// File: rtl/in_quant_packer.sv
// Quantises each raw feature to a 2-bit code against three per-feature thresholds and
// packs NUM_FEATURES codes into one output vector. Optional counters: IN_QUANT_STATS_EN.
module in_quant_packer #(
   parameter int NUM_FEATURES = 16,
   parameter int IN_WIDTH     = 8,
   parameter int BW           = 2
) (
   input  logic             clk,
   input  logic             rst,
   in_quant_packer_if.slave bus
`ifdef IN_QUANT_STATS_EN
   ,
   output logic [15:0]      vec_count,
   output logic [7:0]       err_count
`endif
);
   localparam int OUT_W  = NUM_FEATURES * BW;
   localparam int IDX_W  = $clog2(NUM_FEATURES);
   localparam int CFG_AW = IDX_W + 2;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEATURES - 1);

   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [OUT_W-1:0]    asm_q, asm_d;
   logic [OUT_W-1:0]    m_data_q, m_data_d;
   logic                m_valid_q, m_valid_d;
   logic                err_q, err_d;
   logic [IN_WIDTH-1:0] thr_q [NUM_FEATURES][3];
   logic [IN_WIDTH-1:0] thr_d [NUM_FEATURES][3];

   logic [IDX_W-1:0]    cfg_feat;
   logic [1:0]          cfg_sel;
   logic                at_last;
   logic                s_ready;
   logic                accept;
   logic                complete;
   logic [BW-1:0]       code;
   logic [OUT_W-1:0]    asm_ins;

   assign cfg_feat = bus.cfg_addr[CFG_AW-1:2];
   assign cfg_sel  = bus.cfg_addr[1:0];

   // Only the completing beat can stall: it needs the output register to be free.
   assign at_last  = (idx_q == IDX_LAST);
   assign s_ready  = !(at_last && m_valid_q && !bus.m_ready);
   assign accept   = bus.s_valid && s_ready;
   assign complete = accept && at_last;

   // Thresholds need not be ordered; the code is just how many of the three are met.
   always_comb begin
      code = '0;
      for (int k = 0; k < 3; k++) begin
         code = code + BW'(bus.s_data >= thr_q[idx_q][k]);
      end
   end

   for (genvar gi = 0; gi < NUM_FEATURES; gi++) begin : g_feat
      assign asm_ins[BW*gi +: BW] = (idx_q == IDX_W'(gi)) ? code : asm_q[BW*gi +: BW];
      for (genvar gk = 0; gk < 3; gk++) begin : g_thr
         // sel==3 and out-of-range features never match, so such writes fall away
         assign thr_d[gi][gk] = (bus.cfg_we && cfg_feat == IDX_W'(gi) && cfg_sel == 2'(gk))
                                ? bus.cfg_data : thr_q[gi][gk];
      end
   end

   always_comb begin
      idx_d     = idx_q;
      asm_d     = asm_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      err_d     = 1'b0;
      if (m_valid_q && bus.m_ready) begin
         m_valid_d = 1'b0;
      end
      if (accept) begin
         if (complete) begin
            idx_d     = '0;
            asm_d     = '0;
            m_data_d  = asm_ins;
            m_valid_d = 1'b1;
            err_d     = !bus.s_last;
         end else if (bus.s_last) begin
            idx_d = '0;
            asm_d = '0;
            err_d = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
            asm_d = asm_ins;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         asm_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         err_q     <= 1'b0;
         for (int f = 0; f < NUM_FEATURES; f++) begin
            for (int k = 0; k < 3; k++) begin
               thr_q[f][k] <= '0;
            end
         end
      end else begin
         idx_q     <= idx_d;
         asm_q     <= asm_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         err_q     <= err_d;
         thr_q     <= thr_d;
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.m_valid   = m_valid_q;
   assign bus.m_data    = m_data_q;
   assign bus.err_frame = err_q;

`ifdef IN_QUANT_STATS_EN
   logic [15:0] vec_count_q, vec_count_d;
   logic [7:0]  err_count_q, err_count_d;

   always_comb begin
      vec_count_d = vec_count_q;
      err_count_d = err_count_q;
      if (m_valid_q && bus.m_ready) begin
         vec_count_d = vec_count_q + 16'd1;
      end
      if (err_d && err_count_q != 8'hFF) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_count_q <= '0;
         err_count_q <= '0;
      end else begin
         vec_count_q <= vec_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign vec_count = vec_count_q;
   assign err_count = err_count_q;
`endif
endmodule

// File: doc/in_quant_packer.md
IN_QUANT_PACKER -- requirements
Module: in_quant_packer

Interface
REQ-001 SHALL have parameter NUM_FEATURES, default 16: features packed per output vector (2..64).
REQ-002 SHALL have parameter IN_WIDTH, default 8: unsigned raw feature width.
REQ-003 SHALL have parameter BW, fixed 2: code width per feature; output width OUT_W = NUM_FEATURES*BW.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports s_valid (in, 1), s_ready (out, 1), s_data (in, IN_WIDTH), s_last (in, 1): raw feature stream, one feature per beat.
REQ-007 SHALL have ports m_valid (out, 1), m_ready (in, 1), m_data (out, OUT_W): packed code vector for layer-0 neurons.
REQ-008 SHALL have ports cfg_we (in, 1), cfg_addr (in, clog2(NUM_FEATURES)+2), cfg_data (in, IN_WIDTH): threshold write; addr = {feature, sel}, sel 0..2.
REQ-009 SHALL have port err_frame (out, 1): one-cycle framing-error pulse.

Function
REQ-010 SHALL transfer input on s_valid&&s_ready and output on m_valid&&m_ready.
REQ-011 SHALL compute code = count of thresholds T[f][0..2] with s_data >= T[f][k], where f = current feature index; result 0..3.
REQ-012 SHALL place feature f's code at m_data[BW*f+1 : BW*f] (feature 0 at LSB).
REQ-013 SHALL keep feature index idx, 0..NUM_FEATURES-1, incremented per accepted beat, wrapping to 0 after NUM_FEATURES-1.
REQ-014 SHALL hold an assembly register and an output register; the beat completing idx=NUM_FEATURES-1 moves the assembled vector to the output register and sets m_valid the next cycle (latency 1 cycle from last beat).
REQ-015 SHALL drive s_ready = !(idx==NUM_FEATURES-1 && m_valid && !m_ready); all other beats accepted regardless of output state.
REQ-016 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-017 SHALL, on simultaneous output handshake and completing beat, load the new vector and keep m_valid=1 (zero bubble).
REQ-018 SHALL, if s_last is accepted with idx != NUM_FEATURES-1, discard the partial vector, reset idx to 0, emit nothing, and pulse err_frame.
REQ-019 SHALL, if the completing beat has s_last=0, still emit the vector and pulse err_frame.
REQ-020 SHALL apply cfg writes at the clock edge; beats accepted in the same cycle use the old threshold, later beats use the new one.
REQ-021 SHALL ignore cfg writes with sel=3 or feature >= NUM_FEATURES.
REQ-022 SHALL not require T[f][0] <= T[f][1] <= T[f][2]; counting rule of REQ-011 applies unchanged.

Reset
REQ-023 SHALL on rst clear idx, assembly register, m_data, m_valid, err_frame to 0.
REQ-024 SHALL on rst set all thresholds to 0 except none; s_ready is 1 after reset.
REQ-025 SHALL discard any partial or pending vector when rst asserts mid-stream; no output after release until NUM_FEATURES new beats.

Configuration
REQ-026 SHALL, with macro IN_QUANT_STATS_EN defined, add outputs vec_count (16 bits, counts output handshakes, wraps at 65535->0) and err_count (8 bits, counts err_frame pulses, saturates at 255), both reset to 0.
REQ-027 SHALL, without IN_QUANT_STATS_EN, omit both ports and counters entirely.

Verification
REQ-028 SHALL cover: NUM_FEATURES=4, T[f]={64,128,192}, data 0,64,191,255 with last on 4th, m_ready=1 -> one cycle later m_valid=1, m_data=8'b11_10_01_00.
REQ-029 SHALL cover: m_ready=0, stream two full vectors -> first held stable, s_ready=0 on 2nd vector's last beat until m_ready=1, then both vectors emitted in order, none lost.
REQ-030 SHALL cover: s_last on 2nd beat -> err_frame pulse, no m_valid, next 4 beats produce a correct vector.
REQ-031 SHALL cover: cfg write T[0][0]=10 same cycle as feature-0 beat data=10 (old T=64) -> code 0; next vector same data -> code 1.
REQ-032 SHALL cover: rst asserted after 2 beats and while m_valid=1 -> m_valid=0 and idx=0 immediately; with IN_QUANT_STATS_EN, vec_count=0 after reset and increments by 1 per handshake.
